// File: rtl/sq_pkg.sv
// Shared types and constants for the iterative squarer.
// State encoding, default operand width and the iteration counter width.
package sq_pkg;
  localparam int SQ_WIDTH = 16;
  localparam int CNT_W    = 5;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] END     = 2'd2;
endpackage

// File: rtl/square_datapath.sv
// Shift-add datapath: one multiplier bit per step, accumulator is the result.
// Latency: one cycle per step; no backpressure, driven by the controller.
module square_datapath
  import sq_pkg::*;
#(
  parameter int WIDTH = SQ_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   root,
  output logic [2*WIDTH-1:0] acc,
  output logic               last_iter,
  output logic               b_zero_next
);

  logic [2*WIDTH-1:0] a;
  logic [WIDTH-1:0]   b;
  logic [CNT_W-1:0]   count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a     <= '0;
      b     <= '0;
      acc   <= '0;
      count <= '0;
    end else if (load) begin
      a     <= {{WIDTH{1'b0}}, root};
      b     <= root;
      acc   <= '0;
      count <= '0;
    end else if (step) begin
      if (b[0]) acc <= acc + a;
      a     <= a << 1;
      b     <= b >> 1;
      count <= count + 1'b1;
    end
  end

  assign last_iter   = (count == CNT_W'(WIDTH - 1));
  // True when the current step consumes the last set multiplier bit.
  assign b_zero_next = (b[WIDTH-1:1] == '0);

endmodule

// File: rtl/square_unit.sv
// Iterative squarer, square = root*root; start/done handshake, done strobes WIDTH+1 cycles after start.
// No backpressure: start is only sampled in IDLE. SQUARE_EARLY_EXIT_EN stops once no multiplier bits remain.
module square_unit
  import sq_pkg::*;
#(
  parameter int WIDTH = SQ_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   root,
  output logic [2*WIDTH-1:0] square,
  output logic               done
);

`ifdef SQUARE_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  logic [1:0] state, state_nxt;
  logic       load, step;
  logic       last_iter, b_zero_next;
  logic       finish;

  square_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .step        (step),
    .root        (root),
    .acc         (square),
    .last_iter   (last_iter),
    .b_zero_next (b_zero_next)
  );

  assign load   = (state == IDLE) && start;
  assign step   = (state == COMPUTE);
  assign finish = last_iter || (EARLY_EXIT && b_zero_next);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = COMPUTE;
      COMPUTE: if (finish) state_nxt = END;
      END:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done = 1'b0;
    if (state == END) done = 1'b1;
  end

endmodule
